// File: rtl/pipeline_hazard_ctrl_pkg.sv
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl_pkg: shared types for the hazard sequencer    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic pc_src;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic pipe_hold;
    logic dmem_req;
  } ctrl_t;

  // Everything flushed and frozen while reset is held.
  localparam ctrl_t CTRL_RESET = '{
    pc_write: 1'b0, pc_src: 1'b0, if_id_write: 1'b0,
    if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1,
    pipe_hold: 1'b0, dmem_req: 1'b0
  };

  localparam ctrl_t CTRL_RUN = '{
    pc_write: 1'b1, pc_src: 1'b0, if_id_write: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0,
    pipe_hold: 1'b0, dmem_req: 1'b0
  };

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl_if: pipeline status in, stall/flush ctrl out  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

interface pipeline_hazard_ctrl_if #(
  parameter int REG_W  = 5,
  parameter int PERF_W = 16
);
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  ex_rt;
  logic              ex_mem_read;
  logic              mem_branch;
  logic              mem_zero;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic              dmem_ack;

  logic              pc_write;
  logic              pc_src;
  logic              if_id_write;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              ex_mem_flush;
  logic              pipe_hold;
  logic              dmem_req;
  logic              mem_timeout_err;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, ex_rt, ex_mem_read, mem_branch, mem_zero,
           mem_rd_req, mem_wr_req, dmem_ack,
    input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush,
           ex_mem_flush, pipe_hold, dmem_req, mem_timeout_err, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, ex_rt, ex_mem_read, mem_branch, mem_zero,
           mem_rd_req, mem_wr_req, dmem_ack,
    output pc_write, pc_src, if_id_write, if_id_flush, id_ex_flush,
           ex_mem_flush, pipe_hold, dmem_req, mem_timeout_err, stall_cycles
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_mem_wait_timer.sv
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl_mem_wait_timer: outstanding-access counter    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl_mem_wait_timer #(
  parameter int CNT_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic start,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // start loads 1 because the first stalled cycle happens before entering the wait state.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = CNT_W'(1);
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(MEM_TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// +--------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipe   |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  state_e            state_d;
  state_e            state_q;
  logic              err_d;
  logic              err_q;
  logic [PERF_W-1:0] stall_cycles_d;
  logic [PERF_W-1:0] stall_cycles_q;

  ctrl_t ctrl;
  logic  mem_req;
  logic  branch_taken;
  logic  load_use;
  logic  advance;
  logic  tmr_start;
  logic  tmr_en;
  logic  tmr_clr;
  logic  tmr_tc;

  always_comb begin
    mem_req      = bus.mem_rd_req | bus.mem_wr_req;
    branch_taken = bus.mem_branch & bus.mem_zero;
    load_use     = bus.ex_mem_read
                 && (bus.ex_rt != REG_W'(REG_ZERO))
                 && ((bus.ex_rt == bus.id_rs) || (bus.ex_rt == bus.id_rt));
  end

  always_comb begin
    ctrl      = CTRL_RUN;
    state_d   = state_q;
    err_d     = err_q;
    advance   = 1'b0;
    tmr_start = 1'b0;
    tmr_en    = 1'b0;

    case (state_q)
      ST_RUN: begin
        ctrl.dmem_req = mem_req;
        if (mem_req && !bus.dmem_ack) begin
          ctrl.pipe_hold   = 1'b1;
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          tmr_start        = 1'b1;
          state_d          = ST_MEM_WAIT;
        end else begin
          advance = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        ctrl.dmem_req = 1'b1;
        // The ack cycle is a normal advancing cycle on the inputs that were held.
        if (bus.dmem_ack) begin
          advance = 1'b1;
          state_d = ST_RUN;
        end else begin
          ctrl.pipe_hold   = 1'b1;
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          if (tmr_tc) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
      end

      default: begin
        ctrl.pipe_hold   = 1'b1;
        ctrl.pc_write    = 1'b0;
        ctrl.if_id_write = 1'b0;
        state_d          = ST_ERROR;
        err_d            = 1'b1;
      end
    endcase

    if (advance) begin
      if (branch_taken) begin
        ctrl.pc_src       = 1'b1;
        ctrl.pc_write     = 1'b1;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
        ctrl.ex_mem_flush = 1'b1;
      end else if (load_use) begin
        ctrl.pc_write    = 1'b0;
        ctrl.if_id_write = 1'b0;
        ctrl.id_ex_flush = 1'b1;
      end
    end

    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end
  end

  assign tmr_clr = ~(tmr_start | tmr_en);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (rst_n && !ctrl.pc_write && (stall_cycles_q != {PERF_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      err_q          <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      err_q          <= err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  pipeline_hazard_ctrl_mem_wait_timer #(
    .CNT_W       (CNT_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .start (tmr_start),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  assign bus.pc_write        = ctrl.pc_write;
  assign bus.pc_src          = ctrl.pc_src;
  assign bus.if_id_write     = ctrl.if_id_write;
  assign bus.if_id_flush     = ctrl.if_id_flush;
  assign bus.id_ex_flush     = ctrl.id_ex_flush;
  assign bus.ex_mem_flush    = ctrl.ex_mem_flush;
  assign bus.pipe_hold       = ctrl.pipe_hold;
  assign bus.dmem_req        = ctrl.dmem_req;
  assign bus.mem_timeout_err = err_q;
  assign bus.stall_cycles    = stall_cycles_q;

endmodule

`default_nettype wire
